move_link_ctrl: RTL and testbench
=================================

Name: move_link_ctrl

Overview:
- Reliable move-exchange layer between game_fsm and the byte-level UART tx/rx pair.
- Outbound: takes a move pulse from game_fsm and drives tx. Waits for a peer ACK byte and retransmits on timeout. Flags a link error after repeated failure.
- Inbound: filters rx bytes. Forwards new peer moves upstream as a one-cycle pulse, answers each with an ACK byte, and suppresses duplicate retransmissions.

Parameters:
- CLK_HZ, 65_000_000, system clock frequency (documentation and derived defaults only).
- ACK_TIMEOUT, 6_500_000, clocks to wait for ACK after a move byte finishes (100 ms).
- MAX_RETRY, 3, retransmissions allowed after the first send before declaring error.
- ACK_CODE, 8'hFF, reserved byte meaning ACK. Never a legal move encoding.

Ports:
- clk_in  in  1  system clock (65 MHz).
- rst_in  in  1  synchronous active-high reset.
- send_in  in  1  one-cycle request from game_fsm to transmit move_in.
- move_in  in  8  local move, sampled when send_in=1.
- tx_trigger_out  out  1  one-cycle start pulse to UART tx.
- tx_val_out  out  8  byte to transmit, held stable from trigger until tx_busy_in falls.
- tx_busy_in  in  1  UART tx frame in progress.
- rx_ready_in  in  1  one-cycle pulse: UART rx byte valid.
- rx_data_in  in  8  received byte.
- move_valid_out  out  1  one-cycle pulse: new peer move available.
- move_out  out  8  peer move, valid with move_valid_out and held until the next one.
- busy_out  out  1  high while a local move is unacknowledged.
- link_err_out  out  1  sticky: retries exhausted.
- retry_count_out  out  8  saturating retry statistic (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, ack_pending=0, dup_armed=0, retry counter 0, timer 0. A reset mid-frame abandons the handshake immediately. The tx module handles its own frame abort.
- Outbound FSM states: IDLE, SEND_MOVE, WAIT_TXDONE, WAIT_ACK, SEND_ACK, ACK_TXDONE, ERROR.
- IDLE:
  - If ack_pending, go to SEND_ACK. ACK has priority over a pending move.
  - Else if move_pending, go to SEND_MOVE.
  - send_in latches move_in into move_reg and sets move_pending in any state except ERROR.
  - send_in while busy_out=1 is ignored.
- SEND_MOVE: tx_val_out=move_reg, tx_trigger_out=1 for exactly one cycle, then WAIT_TXDONE.
- WAIT_TXDONE:
  - Wait for tx_busy_in to be seen high, then low.
  - If busy is not seen high within 4 cycles, treat the frame as done.
  - Then clear the timer and go to WAIT_ACK. busy_out=1 from the SEND_MOVE entry until ACK or ERROR.
- WAIT_ACK:
  - Timer increments each cycle.
  - rx byte == ACK_CODE: clear busy_out, clear the retry counter, go to IDLE.
  - Timer reaches ACK_TIMEOUT-1:
    - retries < MAX_RETRY: increment retries, go to SEND_MOVE (same move_reg).
    - otherwise: go to ERROR.
  - If ack_pending rises here, divert to SEND_ACK and return to WAIT_ACK afterwards. The timer keeps running during the detour.
- SEND_ACK / ACK_TXDONE: same as the move path but tx_val_out=ACK_CODE. Clear ack_pending on trigger, then return to the saved state.
- ERROR: link_err_out=1, busy_out=0. Inbound path keeps working. Only rst_in exits.
- Inbound path, independent of FSM, on rx_ready_in:
  - Byte == ACK_CODE: consumed by the FSM only. If not in WAIT_ACK, it is discarded.
  - Other byte with dup_armed=1 and byte == move_out: duplicate. Set ack_pending, no pulse.
  - Otherwise: move_out <= byte, move_valid_out=1 next cycle, ack_pending=1, dup_armed=1.
  - send_in clears dup_armed, because the peer's next legal move always follows ours.
- Simultaneous events:
  - rx move and send_in in the same cycle: both are recorded and the ACK is sent first.
  - ACK arrives in the same cycle the timeout fires: the ACK wins.

Optional Feature:
- Macro LINK_STATS_EN.
- Defined: retry_count_out counts every retransmission since reset, saturating at 255.
- Undefined: retry_count_out is tied to 0 and the counter is not built.

Decomposition:
- Package go_link_pkg holds ACK_CODE default, the link_state_t enum, and the TX_START_GRACE=4 constant.
- Sub-module link_timeout_timer: a counter with clear and enable, and an expired output at ACK_TIMEOUT-1. Reused for the tx-start grace window.

Test Plan:
- Happy path: send_in with move 8'h34, bench tx model busy for 100 cycles, ACK 8'hFF injected 500 cycles later -> exactly one trigger with tx_val_out=8'h34, busy_out falls the cycle after the ACK, link_err_out=0.
- Retry: ACK_TIMEOUT=1000, no ACK until after the 2nd transmission -> 2 triggers carrying 8'h34, ACK accepted, retry_count_out=1 (with LINK_STATS_EN).
- Exhaustion: MAX_RETRY=3, never ACK -> 4 triggers, then link_err_out=1 sticky. A later send_in produces no trigger. rst_in clears the error.
- Inbound plus duplicate: rx 8'h52 twice -> one move_valid_out pulse, move_out=8'h52, two ACK transmissions.
- Collision: rx 8'h21 in the same cycle as send_in with 8'h43 -> ACK byte transmitted first, then 8'h43. move_valid_out pulses once.
- Mid-operation reset: rst_in asserted during WAIT_ACK -> all outputs 0 the next cycle. No trigger until a new send_in.

Source files
------------

// File: rtl/go_link_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// go_link_pkg : shared state encoding and constants for move_link_ctrl
// Rev 1.0
// ------------------------------------------------------------------
package go_link_pkg;

  localparam logic [7:0] ACK_CODE_DEFAULT = 8'hFF;
  localparam int         TX_START_GRACE   = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SEND_MOVE   = 3'd1,
    S_WAIT_TXDONE = 3'd2,
    S_WAIT_ACK    = 3'd3,
    S_SEND_ACK    = 3'd4,
    S_ACK_TXDONE  = 3'd5,
    S_ERROR       = 3'd6
  } link_state_t;

endpackage
`default_nettype wire

// File: rtl/link_timeout_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// link_timeout_timer : clearable up-counter flagging LIMIT-1 cycles
// Rev 1.0
// ------------------------------------------------------------------
module link_timeout_timer #(
  parameter int LIMIT = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int           W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Holds at the last value so an expiry during an ACK detour is still seen on return.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/move_link_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// move_link_ctrl : ACK/retry move exchange over a byte UART pair.
// Optional LINK_STATS_EN builds the saturating retransmission counter.
// Rev 1.0
// ------------------------------------------------------------------
module move_link_ctrl
  import go_link_pkg::*;
#(
  parameter int         CLK_HZ      = 65_000_000,
  parameter int         ACK_TIMEOUT = CLK_HZ / 10,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] ACK_CODE    = ACK_CODE_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       send_in,
  input  logic [7:0] move_in,
  output logic       tx_trigger_out,
  output logic [7:0] tx_val_out,
  input  logic       tx_busy_in,
  input  logic       rx_ready_in,
  input  logic [7:0] rx_data_in,
  output logic       move_valid_out,
  output logic [7:0] move_out,
  output logic       busy_out,
  output logic       link_err_out,
  output logic [7:0] retry_count_out
);

  localparam logic [7:0] MAX_RETRY_B = 8'(MAX_RETRY);

  link_state_t state, ret_state;
  logic [7:0]  move_reg, retries;
  logic        move_pending, ack_pending, dup_armed, seen_busy;
  logic        ack_rx, ack_expired, grace_expired, in_txdone, tx_done;
  logic        take_move, send_ok, retx, ack_timer_clr, ack_timer_en;

  assign ack_rx        = rx_ready_in && (rx_data_in == ACK_CODE);
  assign in_txdone     = (state == S_WAIT_TXDONE) || (state == S_ACK_TXDONE);
  assign tx_done       = in_txdone && !tx_busy_in && (seen_busy || grace_expired);
  assign take_move     = (state == S_IDLE) && !ack_pending && move_pending;
  // A request landing on the cycle the pending move is launched is treated as busy.
  assign send_ok       = send_in && !busy_out && (state != S_ERROR) && !take_move;
  assign retx          = (state == S_WAIT_ACK) && !ack_rx && ack_expired && (retries < MAX_RETRY_B);
  assign ack_timer_clr = (state == S_WAIT_TXDONE) && tx_done;
  assign ack_timer_en  = (state == S_WAIT_ACK) ||
                         (((state == S_SEND_ACK) || (state == S_ACK_TXDONE)) && (ret_state == S_WAIT_ACK));

  link_timeout_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
    .clk(clk_in), .rst(rst_in), .clear(ack_timer_clr), .enable(ack_timer_en), .expired(ack_expired)
  );

  link_timeout_timer #(.LIMIT(TX_START_GRACE)) u_grace_timer (
    .clk(clk_in), .rst(rst_in), .clear(!in_txdone), .enable(in_txdone && !seen_busy),
    .expired(grace_expired)
  );

  // Inbound filter: fresh moves pulse upstream, repeats of the last move only re-ACK.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      move_out       <= '0;
      move_valid_out <= 1'b0;
      ack_pending    <= 1'b0;
      dup_armed      <= 1'b0;
    end else begin
      move_valid_out <= 1'b0;
      if (state == S_SEND_ACK) ack_pending <= 1'b0;
      if (send_ok) dup_armed <= 1'b0;
      if (rx_ready_in && !ack_rx) begin
        ack_pending <= 1'b1;
        if (!(dup_armed && (rx_data_in == move_out))) begin
          move_out       <= rx_data_in;
          move_valid_out <= 1'b1;
          dup_armed      <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      ret_state      <= S_IDLE;
      move_reg       <= '0;
      move_pending   <= 1'b0;
      retries        <= '0;
      seen_busy      <= 1'b0;
      tx_trigger_out <= 1'b0;
      tx_val_out     <= '0;
      busy_out       <= 1'b0;
      link_err_out   <= 1'b0;
    end else begin
      tx_trigger_out <= 1'b0;
      if (send_ok) begin
        move_reg     <= move_in;
        move_pending <= 1'b1;
      end
      if (in_txdone && tx_busy_in) seen_busy <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ack_pending) begin
            ret_state <= S_IDLE;
            state     <= S_SEND_ACK;
          end else if (move_pending) begin
            move_pending <= 1'b0;
            busy_out     <= 1'b1;
            state        <= S_SEND_MOVE;
          end
        end
        S_SEND_MOVE: begin
          tx_val_out     <= move_reg;
          tx_trigger_out <= 1'b1;
          seen_busy      <= 1'b0;
          state          <= S_WAIT_TXDONE;
        end
        S_WAIT_TXDONE: if (tx_done) state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (ack_rx) begin
            busy_out <= 1'b0;
            retries  <= '0;
            state    <= S_IDLE;
          end else if (ack_expired) begin
            if (retx) begin
              retries <= retries + 8'd1;
              state   <= S_SEND_MOVE;
            end else begin
              busy_out     <= 1'b0;
              link_err_out <= 1'b1;
              state        <= S_ERROR;
            end
          end else if (ack_pending) begin
            ret_state <= S_WAIT_ACK;
            state     <= S_SEND_ACK;
          end
        end
        S_SEND_ACK: begin
          tx_val_out     <= ACK_CODE;
          tx_trigger_out <= 1'b1;
          seen_busy      <= 1'b0;
          state          <= S_ACK_TXDONE;
        end
        S_ACK_TXDONE: if (tx_done) state <= ret_state;
        S_ERROR: begin
          busy_out     <= 1'b0;
          link_err_out <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LINK_STATS_EN
  logic [7:0] stats_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stats_cnt <= '0;
    end else if (retx && (stats_cnt != 8'hFF)) begin
      stats_cnt <= stats_cnt + 8'd1;
    end
  end

  assign retry_count_out = stats_cnt;
`else
  assign retry_count_out = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_move_link_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_move_link_ctrl : scoreboard bench with a behavioural UART tx model
// Rev 1.0
// ------------------------------------------------------------------
module tb_move_link_ctrl;

  localparam int         ACK_TO = 1000;
  localparam int         TX_LEN = 100;
  localparam logic [7:0] ACK    = 8'hFF;
`ifdef LINK_STATS_EN
  localparam logic [7:0] EXP_R1 = 8'd1;
  localparam logic [7:0] EXP_R3 = 8'd3;
`else
  localparam logic [7:0] EXP_R1 = 8'd0;
  localparam logic [7:0] EXP_R3 = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] move_i = '0;
  logic       tx_trig;
  logic [7:0] tx_val;
  logic       tx_busy = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       mv_valid;
  logic [7:0] mv_out;
  logic       busy;
  logic       link_err;
  logic [7:0] retry_cnt;

  always #5 clk = ~clk;

  move_link_ctrl #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRY(3)) dut (
    .clk_in(clk), .rst_in(rst), .send_in(send), .move_in(move_i),
    .tx_trigger_out(tx_trig), .tx_val_out(tx_val), .tx_busy_in(tx_busy),
    .rx_ready_in(rx_ready), .rx_data_in(rx_data),
    .move_valid_out(mv_valid), .move_out(mv_out), .busy_out(busy),
    .link_err_out(link_err), .retry_count_out(retry_cnt)
  );

  logic [7:0] tx_q[$];
  logic [7:0] mv_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int trig_count = 0;
  int tx_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // UART tx model plus scoreboard pops, all sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) tx_busy = 1'b0;
    end
    if (tx_trig) begin
      trig_count++;
      tx_busy = 1'b1;
      tx_left = TX_LEN;
      check("tx_trigger_expected", tx_q.size() > 0, 1);
      if (tx_q.size() > 0) begin
        e = tx_q.pop_front();
        check("tx_val", tx_val, e);
      end
    end
    if (mv_valid) begin
      check("move_pulse_expected", mv_q.size() > 0, 1);
      if (mv_q.size() > 0) begin
        e = mv_q.pop_front();
        check("move_out_on_pulse", mv_out, e);
      end
    end
  end

  task automatic pulse_send(input logic [7:0] m);
    send = 1'b1; move_i = m;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trigger"}, tx_trig, 0);
    check({tag, "_tx_val"}, tx_val, 0);
    check({tag, "_move_valid"}, mv_valid, 0);
    check({tag, "_move_out"}, mv_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_link_err"}, link_err, 0);
    check({tag, "_retry_count"}, retry_cnt, 0);
  endtask

  task automatic wait_trig(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (trig_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, trig_count >= target, 1);
  endtask

  typedef struct {
    logic [7:0] rx;
    logic       pulse;
    logic       ack;
    logic [7:0] exp_move;
  } in_vec_t;

  in_vec_t tbl[8];

  initial begin
    int start;
    tbl[0] = '{8'h52, 1'b1, 1'b1, 8'h52};
    tbl[1] = '{8'h52, 1'b0, 1'b1, 8'h52};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 8'h52};
    tbl[3] = '{8'h60, 1'b1, 1'b1, 8'h60};
    tbl[4] = '{8'h60, 1'b0, 1'b1, 8'h60};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{8'h52, 1'b1, 1'b1, 8'h52};

    @(negedge clk);
    do_reset();
    check_zero("reset");

    // Inbound filtering and duplicate suppression
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pulse) mv_q.push_back(tbl[i].rx);
      if (tbl[i].ack) tx_q.push_back(ACK);
      pulse_rx(tbl[i].rx);
      repeat (150) @(negedge clk);
      check($sformatf("in%0d_move_out", i), mv_out, tbl[i].exp_move);
      check($sformatf("in%0d_tx_outstanding", i), tx_q.size(), 0);
      check($sformatf("in%0d_mv_outstanding", i), mv_q.size(), 0);
    end

    // Happy path
    tx_q.push_back(8'h34);
    pulse_send(8'h34);
    repeat (500) @(negedge clk);
    check("happy_busy_before_ack", busy, 1);
    check("happy_tx_outstanding", tx_q.size(), 0);
    pulse_rx(ACK);
    check("happy_busy_after_ack", busy, 0);
    check("happy_link_err", link_err, 0);
    repeat (1200) @(negedge clk);
    check("happy_no_retx", tx_q.size(), 0);

    // Local send re-arms: the peer's same byte is a fresh move
    mv_q.push_back(8'h52);
    tx_q.push_back(ACK);
    pulse_rx(8'h52);
    repeat (150) @(negedge clk);
    check("rearm_mv_outstanding", mv_q.size(), 0);
    check("rearm_tx_outstanding", tx_q.size(), 0);

    // One retransmission before the ACK
    do_reset();
    start = trig_count;
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h34);
    pulse_send(8'h34);
    wait_trig(start + 2, 3000, "retry_second_trigger");
    repeat (150) @(negedge clk);
    check("retry_busy_before_ack", busy, 1);
    pulse_rx(ACK);
    check("retry_busy_after_ack", busy, 0);
    check("retry_count", retry_cnt, EXP_R1);
    repeat (1200) @(negedge clk);
    check("retry_tx_outstanding", tx_q.size(), 0);
    check("retry_link_err", link_err, 0);

    // Exhaustion into sticky error
    do_reset();
    for (int k = 0; k < 4; k++) tx_q.push_back(8'h34);
    pulse_send(8'h34);
    begin
      int n;
      n = 0;
      while (!link_err && n < 6000) begin
        @(negedge clk);
        n++;
      end
    end
    check("exhaust_link_err", link_err, 1);
    check("exhaust_busy", busy, 0);
    check("exhaust_tx_outstanding", tx_q.size(), 0);
    check("exhaust_retry_count", retry_cnt, EXP_R3);
    pulse_send(8'h55);
    mv_q.push_back(8'h77);
    pulse_rx(8'h77);
    repeat (300) @(negedge clk);
    check("error_sticky", link_err, 1);
    check("error_inbound_move", mv_out, 8'h77);
    check("error_mv_outstanding", mv_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("error_reset");
    rst = 1'b0;

    // Collision: peer move and local send in the same cycle
    start = trig_count;
    tx_q.push_back(ACK);
    tx_q.push_back(8'h43);
    mv_q.push_back(8'h21);
    send = 1'b1; move_i = 8'h43; rx_ready = 1'b1; rx_data = 8'h21;
    @(negedge clk);
    send = 1'b0; rx_ready = 1'b0;
    wait_trig(start + 2, 600, "collision_two_triggers");
    repeat (150) @(negedge clk);
    check("collision_busy", busy, 1);
    pulse_rx(ACK);
    check("collision_busy_after_ack", busy, 0);
    check("collision_move_out", mv_out, 8'h21);
    check("collision_mv_outstanding", mv_q.size(), 0);
    check("collision_tx_outstanding", tx_q.size(), 0);

    // Reset in the middle of WAIT_ACK
    start = trig_count;
    tx_q.push_back(8'h34);
    pulse_send(8'h34);
    wait_trig(start + 1, 50, "midrst_trigger");
    repeat (200) @(negedge clk);
    check("midrst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("midrst_no_trigger", trig_count, start + 1);
    check("midrst_tx_outstanding", tx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
